// File: rtl/idu.sv
// RV32I decode stage: one-entry {pc,inst} holding register, decode, operand fetch and next-PC resolution.
// Optional IDU_ILLEGAL_CHK_EN flags unknown opcodes on ill_inst and turns them into an ebreak-carrying NOP.
`timescale 1ns/1ps
module idu #(
   parameter int DATA_WIDTH = 32,
   localparam int EX_W = 4*DATA_WIDTH+16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [2*DATA_WIDTH-1:0] if_to_id_bus,
   input  logic                    if_to_id_valid,
   output logic                    id_to_if_ready,
   output logic [DATA_WIDTH-1:0]   id_to_if_bus,
   output logic                    id_to_if_valid,
   input  logic                    if_to_id_ready,
   output logic [4:0]              rs1_addr,
   output logic [4:0]              rs2_addr,
   input  logic [DATA_WIDTH-1:0]   rs1_data,
   input  logic [DATA_WIDTH-1:0]   rs2_data,
   output logic [EX_W-1:0]         id_to_ex_bus,
   output logic                    id_to_ex_valid,
   input  logic                    ex_to_id_ready,
   output logic                    ill_inst
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   logic                  id_valid;
   logic [DATA_WIDTH-1:0] id_pc;
   logic [DATA_WIDTH-1:0] id_inst;
   logic                  fire_in;
   logic                  fire_out;

   // Fetch never back-pressures dnpc, so its ready is deliberately ignored.
   logic unused;
   assign unused = if_to_id_ready;

   assign fire_out       = id_valid & ex_to_id_ready;
   assign id_to_if_ready = ~id_valid | fire_out;
   assign fire_in        = if_to_id_valid & id_to_if_ready;
   assign id_to_ex_valid = id_valid;
   assign id_to_if_valid = fire_out;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_valid <= 1'b0;
         id_pc    <= '0;
         id_inst  <= '0;
      end else if (fire_in) begin
         id_valid <= 1'b1;
         id_pc    <= if_to_id_bus[2*DATA_WIDTH-1:DATA_WIDTH];
         id_inst  <= if_to_id_bus[DATA_WIDTH-1:0];
      end else if (fire_out) begin
         id_valid <= 1'b0;
      end
   end

   logic [6:0] opcode;
   logic [4:0] rd;
   logic [2:0] funct3;
   assign opcode   = id_inst[6:0];
   assign rd       = id_inst[11:7];
   assign funct3   = id_inst[14:12];
   assign rs1_addr = id_inst[19:15];
   assign rs2_addr = id_inst[24:20];

   logic [DATA_WIDTH-1:0] rs1_val, rs2_val;
   assign rs1_val = (rs1_addr == 5'd0) ? '0 : rs1_data;
   assign rs2_val = (rs2_addr == 5'd0) ? '0 : rs2_data;

   logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   assign imm_i = DATA_WIDTH'($signed(id_inst[31:20]));
   assign imm_s = DATA_WIDTH'($signed({id_inst[31:25], id_inst[11:7]}));
   assign imm_b = DATA_WIDTH'($signed({id_inst[31], id_inst[7], id_inst[30:25], id_inst[11:8], 1'b0}));
   assign imm_u = DATA_WIDTH'($signed({id_inst[31:12], 12'b0}));
   assign imm_j = DATA_WIDTH'($signed({id_inst[31], id_inst[19:12], id_inst[20], id_inst[30:21], 1'b0}));

   // Register-register ops use bit30 for SUB; SRA/SRL is selected by bit30 in both forms.
   logic [3:0] alu_arith;
   always_comb begin
      alu_arith = ALU_ADD;
      case (funct3)
         3'd0: alu_arith = (opcode == OP_OP && id_inst[30]) ? ALU_SUB : ALU_ADD;
         3'd1: alu_arith = ALU_SLL;
         3'd2: alu_arith = ALU_SLT;
         3'd3: alu_arith = ALU_SLTU;
         3'd4: alu_arith = ALU_XOR;
         3'd5: alu_arith = id_inst[30] ? ALU_SRA : ALU_SRL;
         3'd6: alu_arith = ALU_OR;
         default: alu_arith = ALU_AND;
      endcase
   end

   logic taken;
   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'd0: taken = (rs1_val == rs2_val);
         3'd1: taken = (rs1_val != rs2_val);
         3'd4: taken = ($signed(rs1_val) <  $signed(rs2_val));
         3'd5: taken = ($signed(rs1_val) >= $signed(rs2_val));
         3'd6: taken = (rs1_val <  rs2_val);
         3'd7: taken = (rs1_val >= rs2_val);
         default: taken = 1'b0;
      endcase
   end

   logic [DATA_WIDTH-1:0] src1, src2, imm, dnpc;
   logic [3:0]            alu_op;
   logic                  use_rs2, wen_raw, mem_rd_raw, mem_wr_raw, ebreak_raw;

   always_comb begin
      src1       = rs1_val;
      imm        = '0;
      alu_op     = ALU_ADD;
      use_rs2    = 1'b0;
      wen_raw    = 1'b0;
      mem_rd_raw = 1'b0;
      mem_wr_raw = 1'b0;
      ebreak_raw = 1'b0;
      dnpc       = id_pc + DATA_WIDTH'(4);
      case (opcode)
         OP_LUI: begin
            src1    = '0;
            imm     = imm_u;
            alu_op  = ALU_PASSB;
            wen_raw = 1'b1;
         end
         OP_AUIPC: begin
            src1    = id_pc;
            imm     = imm_u;
            wen_raw = 1'b1;
         end
         OP_JAL: begin
            src1    = id_pc;
            imm     = DATA_WIDTH'(4);
            wen_raw = 1'b1;
            dnpc    = id_pc + imm_j;
         end
         OP_JALR: begin
            src1    = id_pc;
            imm     = DATA_WIDTH'(4);
            wen_raw = 1'b1;
            dnpc    = (rs1_val + imm_i) & ~DATA_WIDTH'(1);
         end
         OP_IMM: begin
            imm     = imm_i;
            alu_op  = alu_arith;
            wen_raw = 1'b1;
         end
         OP_OP: begin
            use_rs2 = 1'b1;
            alu_op  = alu_arith;
            wen_raw = 1'b1;
         end
         OP_LOAD: begin
            imm        = imm_i;
            wen_raw    = 1'b1;
            mem_rd_raw = 1'b1;
         end
         OP_STORE: begin
            imm        = imm_s;
            use_rs2    = 1'b1;
            mem_wr_raw = 1'b1;
         end
         OP_BRANCH: begin
            imm     = imm_b;
            use_rs2 = 1'b1;
            alu_op  = ALU_SUB;
            if (taken) dnpc = id_pc + imm_b;
         end
         OP_SYSTEM: begin
            imm        = imm_i;
            ebreak_raw = (id_inst == DATA_WIDTH'(EBREAK_INST));
         end
         default: ;
      endcase
      src2 = use_rs2 ? rs2_val : imm;
   end

   logic kill;
`ifdef IDU_ILLEGAL_CHK_EN
   logic legal;
   always_comb begin
      legal = 1'b0;
      case (opcode)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP,
         OP_LOAD, OP_STORE, OP_BRANCH: legal = 1'b1;
         OP_SYSTEM: legal = (id_inst == DATA_WIDTH'(EBREAK_INST));
         default:   legal = 1'b0;
      endcase
   end
   assign kill     = ~legal;
   assign ill_inst = id_valid & ~legal;
`else
   assign kill     = 1'b0;
   assign ill_inst = 1'b0;
`endif

   // An illegal word becomes a NOP that still halts the simulator via ebreak.
   logic       wen, mem_rd, mem_wr, ebreak;
   logic [4:0] rd_out;
   assign wen    = wen_raw & (rd != 5'd0) & ~kill;
   assign mem_rd = mem_rd_raw & ~kill;
   assign mem_wr = mem_wr_raw & ~kill;
   assign ebreak = ebreak_raw | kill;
   assign rd_out = wen ? rd : 5'd0;

   assign id_to_if_bus = dnpc;
   assign id_to_ex_bus = {id_pc, src1, src2, imm, rd_out, alu_op, funct3, wen, mem_rd, mem_wr, ebreak};
endmodule

// File: tb/tb_idu.sv
// Self-checking bench for idu: directed scenarios plus a randomized handshake run against a behavioural model.
`timescale 1ns/1ps
module tb_idu;
   localparam int DW = 32;
   localparam int EW = 4*DW+16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [2*DW-1:0] if_to_id_bus = '0;
   logic          if_to_id_valid = 1'b0;
   logic          id_to_if_ready;
   logic [DW-1:0] id_to_if_bus;
   logic          id_to_if_valid;
   logic          if_to_id_ready = 1'b1;
   logic [4:0]    rs1_addr, rs2_addr;
   logic [DW-1:0] rs1_data, rs2_data;
   logic [EW-1:0] id_to_ex_bus;
   logic          id_to_ex_valid;
   logic          ex_to_id_ready = 1'b0;
   logic          ill_inst;

   logic [DW-1:0] regs [32];
   assign rs1_data = regs[rs1_addr];
   assign rs2_data = regs[rs2_addr];

   int checks = 0;
   int fails  = 0;

   idu dut (
      .clk(clk), .rst(rst),
      .if_to_id_bus(if_to_id_bus), .if_to_id_valid(if_to_id_valid), .id_to_if_ready(id_to_if_ready),
      .id_to_if_bus(id_to_if_bus), .id_to_if_valid(id_to_if_valid), .if_to_id_ready(if_to_id_ready),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .id_to_ex_bus(id_to_ex_bus), .id_to_ex_valid(id_to_ex_valid), .ex_to_id_ready(ex_to_id_ready),
      .ill_inst(ill_inst)
   );

   always #5 clk = ~clk;

   logic [31:0] f_pc, f_src1, f_src2, f_imm;
   logic [4:0]  f_rd;
   logic [3:0]  f_alu;
   logic [2:0]  f_f3;
   logic        f_wen, f_mrd, f_mwr, f_ebk;
   assign {f_pc, f_src1, f_src2, f_imm, f_rd, f_alu, f_f3, f_wen, f_mrd, f_mwr, f_ebk} = id_to_ex_bus;

   // Reference decode from the ISA rules; fields the core leaves unspecified are masked out.
   function automatic void model(input logic [31:0] pc, input logic [31:0] inst,
                                 output logic [EW-1:0] eb, output logic [EW-1:0] mk,
                                 output logic [31:0] np, output logic il);
      logic [6:0] opc;
      logic [2:0] f3;
      logic [4:0] rd;
      logic [31:0] r1, r2, ii, is, ib, iu, ij, s1, s2, im;
      logic [3:0] alu;
      logic w, mrd, mwr, ebk, legal, c1, c2, ci, ca, tk;
      logic [3:0] alu_tab [8];
      alu_tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
      opc = inst[6:0];
      f3  = inst[14:12];
      rd  = inst[11:7];
      r1  = (inst[19:15] == 0) ? 32'h0 : regs[inst[19:15]];
      r2  = (inst[24:20] == 0) ? 32'h0 : regs[inst[24:20]];
      ii  = 32'($signed(inst) >>> 20);
      is  = (32'($signed(inst) >>> 20) & 32'hFFFF_FFE0) | 32'(inst[11:7]);
      iu  = inst & 32'hFFFF_F000;
      ib  = (inst[31] ? 32'hFFFF_F000 : 32'h0) + (32'(inst[7]) << 11) + (32'(inst[30:25]) << 5) + (32'(inst[11:8]) << 1);
      ij  = (inst[31] ? 32'hFFF0_0000 : 32'h0) + (32'(inst[19:12]) << 12) + (32'(inst[20]) << 11) + (32'(inst[30:21]) << 1);
      s1 = r1; s2 = ii; im = ii; alu = 4'd0;
      c1 = 1'b0; c2 = 1'b0; ci = 1'b0; ca = 1'b0;
      w = 1'b0; mrd = 1'b0; mwr = 1'b0; ebk = 1'b0; legal = 1'b1; tk = 1'b0;
      np = pc + 32'd4;
      case (opc)
         7'h37: begin s2 = iu; im = iu; alu = 4'd10; w = 1; c2 = 1; ci = 1; ca = 1; end
         7'h17: begin s1 = pc; s2 = iu; im = iu; w = 1; c1 = 1; c2 = 1; ci = 1; ca = 1; end
         7'h6f: begin s1 = pc; s2 = 4; im = 4; w = 1; c1 = 1; c2 = 1; ci = 1; ca = 1; np = pc + ij; end
         7'h67: begin s1 = pc; s2 = 4; im = 4; w = 1; c1 = 1; c2 = 1; ci = 1; ca = 1; np = (r1 + ii) & 32'hFFFF_FFFE; end
         7'h13, 7'h33: begin
            alu = alu_tab[f3];
            if (f3 == 3'd0 && opc == 7'h33 && inst[30]) alu = 4'd1;
            if (f3 == 3'd5 && inst[30]) alu = 4'd7;
            if (opc == 7'h33) s2 = r2;
            w = 1; c1 = 1; c2 = 1; ca = 1; ci = (opc == 7'h13);
         end
         7'h03: begin w = 1; mrd = 1; c1 = 1; c2 = 1; ci = 1; ca = 1; end
         7'h23: begin s2 = r2; im = is; mwr = 1; c1 = 1; c2 = 1; ci = 1; ca = 1; end
         7'h63: begin
            s2 = r2; im = ib; c1 = 1; c2 = 1; ci = 1;
            case (f3)
               3'd0: tk = (r1 == r2);
               3'd1: tk = (r1 != r2);
               3'd4: tk = ($signed(r1) <  $signed(r2));
               3'd5: tk = ($signed(r1) >= $signed(r2));
               3'd6: tk = (r1 <  r2);
               3'd7: tk = (r1 >= r2);
               default: tk = 1'b0;
            endcase
            if (tk) np = pc + ib;
         end
         7'h73: begin ebk = (inst == 32'h0010_0073); legal = ebk; end
         default: legal = 1'b0;
      endcase
      if (rd == 5'd0) w = 1'b0;
      il = 1'b0;
`ifdef IDU_ILLEGAL_CHK_EN
      if (!legal) begin w = 0; mrd = 0; mwr = 0; ebk = 1; il = 1; end
`endif
      eb = {pc, s1, s2, im, (w ? rd : 5'd0), alu, f3, w, mrd, mwr, ebk};
      mk = {32'hFFFF_FFFF, {32{c1}}, {32{c2}}, {32{ci}}, 5'h1F, {4{ca}}, 3'h7, 4'hF};
   endfunction

   function automatic logic [31:0] gen_inst();
      logic [31:0] w;
      logic [2:0] btab [6];
      btab = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      w = $urandom();
      if ($urandom_range(0, 3) == 0) w[19:15] = 5'd0;
      if ($urandom_range(0, 3) == 0) w[24:20] = 5'd0;
      case ($urandom_range(0, 11))
         0: w[6:0] = 7'h37;
         1: w[6:0] = 7'h17;
         2: w[6:0] = 7'h6f;
         3: begin w[6:0] = 7'h67; w[14:12] = 3'd0; end
         4: w[6:0] = 7'h13;
         5: begin w[6:0] = 7'h33; w[31:25] = {1'b0, w[30], 5'b0}; end
         6: w[6:0] = 7'h03;
         7: w[6:0] = 7'h23;
         8: begin w[6:0] = 7'h63; w[14:12] = btab[$urandom_range(0, 5)]; end
         9: w = 32'h0010_0073;
         10: ;
         default: w[6:0] = 7'h73;
      endcase
      return w;
   endfunction

   task automatic send(input logic [31:0] pc, input logic [31:0] inst);
      if_to_id_valid = 1'b1;
      if_to_id_bus   = {pc, inst};
      @(posedge clk); #1;
      if_to_id_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (id_to_ex_valid !== 1'b0) begin fails++; $display("FAIL reset_ex_valid: got %b expected 0", id_to_ex_valid); end
      checks++; if (id_to_if_valid !== 1'b0) begin fails++; $display("FAIL reset_if_valid: got %b expected 0", id_to_if_valid); end
      checks++; if (id_to_if_ready !== 1'b1) begin fails++; $display("FAIL reset_if_ready: got %b expected 1", id_to_if_ready); end
      checks++; if (ill_inst !== 1'b0) begin fails++; $display("FAIL reset_ill: got %b expected 0", ill_inst); end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_addi();
      regs[0] = 32'hDEAD_BEEF;
      ex_to_id_ready = 1'b1;
      send(32'h8000_0000, 32'h0050_0093);
      @(negedge clk);
      checks++; if (id_to_ex_valid !== 1'b1) begin fails++; $display("FAIL addi_valid: got %b expected 1", id_to_ex_valid); end
      checks++; if (f_src1 !== 32'h0) begin fails++; $display("FAIL addi_src1: got %h expected 0", f_src1); end
      checks++; if (f_imm !== 32'h5) begin fails++; $display("FAIL addi_imm: got %h expected 5", f_imm); end
      checks++; if ({f_alu, f_rd, f_wen} !== {4'd0, 5'd1, 1'b1}) begin fails++; $display("FAIL addi_ctrl: got alu=%0d rd=%0d wen=%b expected 0 1 1", f_alu, f_rd, f_wen); end
      checks++; if (id_to_if_valid !== 1'b1) begin fails++; $display("FAIL addi_dnpc_valid: got %b expected 1", id_to_if_valid); end
      checks++; if (id_to_if_bus !== 32'h8000_0004) begin fails++; $display("FAIL addi_dnpc: got %h expected 80000004", id_to_if_bus); end
      @(posedge clk); #1;
   endtask

   task automatic test_branch();
      regs[1] = 32'd7; regs[2] = 32'd7;
      send(32'h8000_0010, 32'h0020_8463);
      @(negedge clk);
      checks++; if (id_to_if_bus !== 32'h8000_0018) begin fails++; $display("FAIL beq_taken: got %h expected 80000018", id_to_if_bus); end
      checks++; if ({f_wen, f_rd} !== 6'd0) begin fails++; $display("FAIL beq_wen: got wen=%b rd=%0d expected 0 0", f_wen, f_rd); end
      @(posedge clk); #1;
      regs[2] = 32'd8;
      send(32'h8000_0010, 32'h0020_8463);
      @(negedge clk);
      checks++; if (id_to_if_bus !== 32'h8000_0014) begin fails++; $display("FAIL beq_not_taken: got %h expected 80000014", id_to_if_bus); end
      @(posedge clk); #1;
   endtask

   task automatic test_jalr();
      regs[5] = 32'h8000_0101;
      send(32'h8000_0040, 32'h0042_80E7);
      @(negedge clk);
      checks++; if (id_to_if_bus !== 32'h8000_0104) begin fails++; $display("FAIL jalr_dnpc: got %h expected 80000104", id_to_if_bus); end
      checks++; if (f_src1 !== 32'h8000_0040) begin fails++; $display("FAIL jalr_src1: got %h expected 80000040", f_src1); end
      checks++; if ({f_imm, f_rd, f_wen} !== {32'd4, 5'd1, 1'b1}) begin fails++; $display("FAIL jalr_ctrl: got imm=%h rd=%0d wen=%b expected 4 1 1", f_imm, f_rd, f_wen); end
      @(posedge clk); #1;
   endtask

   task automatic test_stall();
      logic [EW-1:0] snap;
      ex_to_id_ready = 1'b0;
      send(32'h8000_0100, 32'h0010_0193);
      if_to_id_valid = 1'b1;
      if_to_id_bus   = {32'h8000_0104, 32'h0020_0213};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (k == 0) snap = id_to_ex_bus;
         checks++; if (id_to_if_ready !== 1'b0) begin fails++; $display("FAIL stall_ready c%0d: got %b expected 0", k, id_to_if_ready); end
         checks++; if (id_to_if_valid !== 1'b0) begin fails++; $display("FAIL stall_dnpc c%0d: got %b expected 0", k, id_to_if_valid); end
         checks++; if (id_to_ex_bus !== snap || f_pc !== 32'h8000_0100) begin fails++; $display("FAIL stall_bus c%0d: got pc %h expected 80000100", k, f_pc); end
      end
      @(posedge clk); #1;
      ex_to_id_ready = 1'b1;
      @(negedge clk);
      checks++; if ({id_to_if_ready, id_to_if_valid} !== 2'b11) begin fails++; $display("FAIL release_hs: got ready=%b dnpc_valid=%b expected 1 1", id_to_if_ready, id_to_if_valid); end
      checks++; if (id_to_if_bus !== 32'h8000_0104) begin fails++; $display("FAIL release_dnpc: got %h expected 80000104", id_to_if_bus); end
      @(posedge clk); #1;
      if_to_id_valid = 1'b0;
      @(negedge clk);
      checks++; if ({id_to_ex_valid, f_pc, f_rd} !== {1'b1, 32'h8000_0104, 5'd4}) begin fails++; $display("FAIL b2b_word: got valid=%b pc=%h rd=%0d expected 1 80000104 4", id_to_ex_valid, f_pc, f_rd); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      ex_to_id_ready = 1'b0;
      send(32'h8000_0300, 32'h0010_0193);
      @(negedge clk);
      checks++; if (id_to_ex_valid !== 1'b1) begin fails++; $display("FAIL rstmid_held: got %b expected 1", id_to_ex_valid); end
      #2 rst = 1'b0;
      #1;
      checks++; if ({id_to_ex_valid, id_to_if_ready, id_to_if_valid} !== 3'b010) begin fails++; $display("FAIL rstmid_async: got ex_valid=%b ready=%b dnpc_valid=%b expected 0 1 0", id_to_ex_valid, id_to_if_ready, id_to_if_valid); end
      @(posedge clk); #1;
      ex_to_id_ready = 1'b1;
      @(negedge clk); #2 rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if ({id_to_ex_valid, id_to_if_valid} !== 2'b00) begin fails++; $display("FAIL rstmid_after c%0d: got ex_valid=%b dnpc_valid=%b expected 0 0", k, id_to_ex_valid, id_to_if_valid); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_illegal();
      ex_to_id_ready = 1'b1;
      send(32'h8000_0200, 32'hFFFF_FFFF);
      @(negedge clk);
`ifdef IDU_ILLEGAL_CHK_EN
      checks++; if ({ill_inst, f_ebk, f_wen, f_mrd, f_mwr} !== 5'b11000) begin fails++; $display("FAIL illegal_flags: got ill=%b ebreak=%b wen=%b rd=%b wr=%b expected 1 1 0 0 0", ill_inst, f_ebk, f_wen, f_mrd, f_mwr); end
`else
      checks++; if ({ill_inst, f_ebk, f_wen, f_mrd, f_mwr} !== 5'b00000) begin fails++; $display("FAIL illegal_nop: got ill=%b ebreak=%b wen=%b rd=%b wr=%b expected 0 0 0 0 0", ill_inst, f_ebk, f_wen, f_mrd, f_mwr); end
`endif
      checks++; if (id_to_if_bus !== 32'h8000_0204) begin fails++; $display("FAIL illegal_dnpc: got %h expected 80000204", id_to_if_bus); end
      @(posedge clk); #1;
      send(32'h8000_0208, 32'h0010_0073);
      @(negedge clk);
      checks++; if ({ill_inst, f_ebk, f_wen} !== 3'b010) begin fails++; $display("FAIL ebreak_flags: got ill=%b ebreak=%b wen=%b expected 0 1 0", ill_inst, f_ebk, f_wen); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [63:0] q[$];
      logic [EW-1:0] eb, mk;
      logic [31:0] np;
      logic il, ev, fo, fi, rdy;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < 32; i++)
            regs[i] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) - 32'd2 : $urandom();
         if_to_id_valid = ($urandom_range(0, 3) != 0);
         if_to_id_bus   = {$urandom() & 32'hFFFF_FFFC, gen_inst()};
         ex_to_id_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         ev  = (q.size() != 0);
         fo  = ev && ex_to_id_ready;
         rdy = !ev || ex_to_id_ready;
         il  = 1'b0;
         if (ev) model(q[0][63:32], q[0][31:0], eb, mk, np, il);
         checks++; if ({id_to_ex_valid, id_to_if_ready, id_to_if_valid} !== {ev, rdy, fo}) begin fails++; $display("FAIL rnd_hs c%0d: got %b%b%b expected %b%b%b", c, id_to_ex_valid, id_to_if_ready, id_to_if_valid, ev, rdy, fo); end
         checks++; if (ill_inst !== il) begin fails++; $display("FAIL rnd_ill c%0d: got %b expected %b", c, ill_inst, il); end
         if (ev) begin
            checks++; if ((id_to_ex_bus & mk) !== (eb & mk)) begin fails++; $display("FAIL rnd_bus c%0d inst %h: got %h expected %h", c, q[0][31:0], id_to_ex_bus & mk, eb & mk); end
            checks++; if (id_to_if_bus !== np) begin fails++; $display("FAIL rnd_dnpc c%0d inst %h: got %h expected %h", c, q[0][31:0], id_to_if_bus, np); end
         end
         fi = if_to_id_valid && rdy;
         @(posedge clk); #1;
         if (fo) void'(q.pop_front());
         if (fi) q.push_back(if_to_id_bus);
      end
      if_to_id_valid = 1'b0;
      ex_to_id_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom();
      test_reset();
      test_addi();
      test_branch();
      test_jalr();
      test_stall();
      test_reset_mid();
      test_illegal();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
